// File: rtl/bka_pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module      : bka_pipe_addsub
// Description : Parametrised Brent-Kung prefix adder/subtractor with a
//               configurable number of pipeline stages and a bubble-collapsing
//               valid/ready handshake on both sides.
// Revision    : 1.0 - initial release (generic width, cin/cout, sub, flags)
// ============================================================================
module bka_pipe_addsub #(
  parameter int WIDTH = 16,
  parameter int PIPE  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int LG = $clog2(WIDTH);
  localparam int L  = 2*LG - 1;                 // prefix levels
  localparam int NB = (PIPE > 1) ? PIPE-1 : 1;  // internal bundle registers

  // Everything a later level needs: original propagate (for the sum),
  // group generate/propagate, folded carry-in and the operand sign bits.
  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic             c0;
    logic             am;
    logic             bm;
  } bnd_t;

  // Prefix level after which internal register s sits.
  function automatic int cut_level(input int s);
    return (s*L + PIPE - 1) / PIPE;
  endfunction

  // Register index that sits after prefix level lvl, 0 when none does.
  function automatic int stage_after(input int lvl);
    int r;
    r = 0;
    for (int s = 1; s < PIPE; s++)
      if (cut_level(s) == lvl) r = s;
    return r;
  endfunction

  // Per-bit propagate/generate; carry-in enters as the bit -1 generate,
  // folded into bit 0 so the tree yields G[i:-1] = carry into bit i+1.
  function automatic bnd_t pg_stage(input logic [WIDTH-1:0] fa,
                                    input logic [WIDTH-1:0] fb,
                                    input logic fcin, input logic fsub);
    bnd_t             r;
    logic [WIDTH-1:0] bb;
    bb     = fsub ? ~fb : fb;
    r.c0   = fsub ^ fcin;
    r.x    = fa ^ bb;
    r.g    = fa & bb;
    r.p    = r.x;
    r.g[0] = r.g[0] | (r.x[0] & r.c0);
    r.p[0] = 1'b0;
    r.am   = fa[WIDTH-1];
    r.bm   = bb[WIDTH-1];
    return r;
  endfunction

  // One Brent-Kung level: levels 1..LG form the up-sweep, the rest the
  // down-sweep filling in the intermediate carries.
  function automatic bnd_t prefix_level(input bnd_t s, input int lvl);
    bnd_t r;
    int   span;
    int   half;
    int   j;
    logic hit;
    r = s;
    if (lvl <= LG) span = 1 << lvl;
    else           span = 1 << (2*LG - lvl);
    half = span / 2;
    for (int i = 0; i < WIDTH; i++) begin
      if (lvl <= LG) hit = ((i + 1) % span) == 0;
      else           hit = (i >= span) && ((i % span) == half - 1);
      if (hit) begin
        j      = i - half;
        r.g[i] = s.g[i] | (s.p[i] & s.g[j]);
        r.p[i] = s.p[i] & s.p[j];
      end
    end
    return r;
  endfunction

  // Final XOR plus flags, packed as {q, cout, ovf, zero}.
  function automatic logic [WIDTH+2:0] sum_stage(input bnd_t s);
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] sq;
    logic             sovf;
    c    = {s.g[WIDTH-2:0], s.c0};
    sq   = s.x ^ c;
    sovf = (s.am == s.bm) && (sq[WIDTH-1] != s.am);
    return {sq, s.g[WIDTH-1], sovf, ~|sq};
  endfunction

  bnd_t             w_lvl [0:L];   // combinational output of each level
  bnd_t             w_src [0:L];   // what the following level consumes
  bnd_t             r_bnd [0:NB-1];
  logic [PIPE:1]    r_v;
  logic [PIPE:1]    w_rdy;
  logic [PIPE:1]    w_vin;
  logic [WIDTH+2:0] w_res;

  assign w_lvl[0] = pg_stage(a, b, cin, sub);

  for (genvar l = 0; l <= L; l++) begin : g_src
    if (stage_after(l) != 0) begin : g_reg
      assign w_src[l] = r_bnd[stage_after(l)-1];
    end else begin : g_comb
      assign w_src[l] = w_lvl[l];
    end
  end

  for (genvar l = 1; l <= L; l++) begin : g_lvl
    assign w_lvl[l] = prefix_level(w_src[l-1], l);
  end

  assign w_res = sum_stage(w_src[L]);

  // A stage can take new data when empty or when everything downstream moves.
  for (genvar k = 1; k <= PIPE; k++) begin : g_hs
    assign w_rdy[k] = out_ready | ~(&r_v[PIPE:k]);
    if (k == 1) begin : g_first
      assign w_vin[k] = in_valid;
    end else begin : g_rest
      assign w_vin[k] = r_v[k-1];
    end
  end

  assign in_ready  = w_rdy[1];
  assign out_valid = r_v[PIPE];

  // Valid bits advance wherever the stage is ready, collapsing bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
    end else begin
      for (int k = 1; k <= PIPE; k++)
        if (w_rdy[k]) r_v[k] <= w_vin[k];
    end
  end

  if (PIPE > 1) begin : g_cuts
    for (genvar s = 1; s < PIPE; s++) begin : g_stg
      // Capture the prefix state only for a real operand moving in.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     r_bnd[s-1] <= '0;
        else if (w_rdy[s] && w_vin[s])  r_bnd[s-1] <= w_lvl[cut_level(s)];
      end
    end
  end else begin : g_nocut
    assign r_bnd[0] = '0;
  end

  // Output register: loads only on a real operand, holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else if (w_rdy[PIPE] && w_vin[PIPE]) begin
      {q, cout, ovf, zero} <= w_res;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bka_pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_bka_pipe_addsub
// Description : Scoreboard bench for bka_pipe_addsub (WIDTH=16, PIPE=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bka_pipe_addsub;

  localparam int W = 16;
  localparam int P = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] q;
  logic         cout;
  logic         ovf;
  logic         zero;

  int checks = 0;
  int failures = 0;
  int n_out = 0;
  logic [W+2:0] exp_q [$];
  logic         held = 1'b0;
  logic [W+2:0] held_val = '0;
  logic         rand_rdy = 1'b0;

  always #5 clk = ~clk;

  bka_pipe_addsub #(.WIDTH(W), .PIPE(P)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .q(q), .cout(cout), .ovf(ovf), .zero(zero)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Independent reference: plain integer arithmetic on W+1 bits.
  function automatic logic [W+2:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc, input logic ms);
    logic [W-1:0] bb;
    logic [W:0]   s;
    logic         v;
    bb = ms ? ~mb : mb;
    s  = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, ms ? ~mc : mc};
    v  = (ma[W-1] == bb[W-1]) && (s[W-1] != ma[W-1]);
    return {s[W-1:0], s[W], v, s[W-1:0] == '0};
  endfunction

  // Monitor: pops on every output transfer and checks stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", {31'b0, out_valid}, 32'd1);
        check("hold_data", {13'b0, q, cout, ovf, zero}, {13'b0, held_val});
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) check("unexpected_out", {13'b0, q, cout, ovf, zero}, 32'hFFFF_FFFF);
        else check("result", {13'b0, q, cout, ovf, zero}, {13'b0, exp_q.pop_front()});
      end
      held     = out_valid && !out_ready;
      held_val = {q, cout, ovf, zero};
    end
  end

  always @(posedge clk) if (rand_rdy) #1 out_ready = 1'($urandom_range(0, 1));

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                       input logic is, input logic [W+2:0] e, output int waited);
    logic ok;
    ok = 1'b0;
    waited = 0;
    in_valid = 1'b1; a = ia; b = ib; cin = ic; sub = is;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        ok = 1'b1;
        break;
      end
      waited++;
    end
    if (!ok) check("issue_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(negedge clk);
    check("drain", exp_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  // Directed vectors: {a, b, cin, sub} and hand-computed {q, cout, ovf, zero}.
  logic [W*2+1:0] vin  [8] = '{
    {16'hFFFF, 16'h0000, 1'b1, 1'b0}, {16'h7FFF, 16'h0001, 1'b0, 1'b0},
    {16'h0005, 16'h0007, 1'b0, 1'b1}, {16'h8000, 16'h0001, 1'b0, 1'b1},
    {16'h0005, 16'h0005, 1'b1, 1'b1}, {16'h1234, 16'h4321, 1'b0, 1'b0},
    {16'h1234, 16'h1234, 1'b0, 1'b1}, {16'h00FF, 16'h0001, 1'b0, 1'b0}};
  logic [W+2:0]   vexp [8] = '{
    {16'h0000, 3'b101}, {16'h8000, 3'b010}, {16'hFFFE, 3'b000}, {16'h7FFF, 3'b110},
    {16'hFFFF, 3'b000}, {16'h5555, 3'b000}, {16'h0000, 3'b101}, {16'h0100, 3'b000}};

  initial begin : main
    int lat;
    int w;
    int idx;
    int base;
    logic acc;
    logic seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rc;
    logic rs;

    // 1. Reset with in_valid held high.
    in_valid = 1'b1; a = 16'h0003; b = 16'h0004;
    repeat (3) begin
      @(negedge clk);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_outputs", {13'b0, q, cout, ovf, zero}, 32'd0);
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("first_accept", {31'b0, in_ready}, 32'd1);
    exp_q.push_back({16'h0007, 3'b000});
    @(posedge clk); #1 in_valid = 1'b0;
    lat = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check("latency", lat, P);
    wait_drain();

    // 2/3. Carry chain, overflow and subtract vectors.
    for (int i = 0; i < 8; i++)
      issue(vin[i][33:18], vin[i][17:2], vin[i][1], vin[i][0], vexp[i], w);
    wait_drain();

    // 4. Back-pressure: 8 streamed operands, consumer stalled 5 cycles.
    base = n_out;
    out_ready = 1'b0;
    idx = 0;
    in_valid = 1'b1; a = 16'h0010; b = 16'h0001; cin = 1'b0; sub = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      check("bp_in_ready", {31'b0, in_ready}, (cyc < 2) ? 32'd1 : 32'd0);
      acc = in_ready;
      if (acc) exp_q.push_back({16'(16'h0011 * (idx + 1)), 3'b000});
      @(posedge clk); #1;
      if (acc) begin idx++; a = 16'(16'h0010 * (idx + 1)); b = 16'(idx + 1); end
    end
    out_ready = 1'b1;
    for (int n = 0; n < 100 && idx < 8; n++) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) exp_q.push_back({16'(16'h0011 * (idx + 1)), 3'b000});
      @(posedge clk); #1;
      if (acc) begin idx++; a = 16'(16'h0010 * (idx + 1)); b = 16'(idx + 1); end
    end
    in_valid = 1'b0;
    wait_drain();
    check("bp_count", n_out - base, 32'd8);

    // 5. Bubble collapse with the consumer stalled.
    out_ready = 1'b0;
    issue(16'h0100, 16'h0023, 1'b0, 1'b0, {16'h0123, 3'b000}, w);
    @(negedge clk);
    check("bubble_idle_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    issue(16'h0400, 16'h0056, 1'b1, 1'b0, {16'h0457, 3'b000}, w);
    check("bubble_second_wait", w, 32'd0);
    @(negedge clk);
    check("bubble_full", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check("bubble_out1", {31'b0, out_valid}, 32'd1);
    @(negedge clk);
    check("bubble_out2", {31'b0, out_valid}, 32'd1);
    wait_drain();

    // 6. Random stream against the model with random back-pressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      if (i % 7 == 3) begin ra = 16'hFFFF; rb = 16'h0000; rc = 1'b1; rs = 1'b0; end
      issue(ra, rb, rc, rs, model(ra, rb, rc, rs), w);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    @(posedge clk); rand_rdy = 1'b0; #2 out_ready = 1'b1;
    wait_drain();

    // Mid-stream reset: in-flight results must vanish.
    out_ready = 1'b0;
    issue(16'h0001, 16'h0001, 1'b0, 1'b0, {16'h0002, 3'b000}, w);
    issue(16'h0002, 16'h0002, 1'b0, 1'b0, {16'h0004, 3'b000}, w);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_q", {13'b0, q, cout, ovf, zero}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; out_ready = 1'b1;
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    check("no_stale", {31'b0, seen}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/bka_pipe_addsub.md
Name: bka_pipe_addsub

Overview:
- Parametrised, pipelined Brent-Kung prefix adder/subtractor; successor to the fixed 16-bit, no-carry-in/no-carry-out Brent-Kung adder.
- Adds generic width, carry-in and carry-out, a subtract mode, signed-overflow and zero flags, and configurable pipeline depth.
- Uses a valid/ready handshake on both sides.
- Sits between operand-issue logic and the datapath writeback; a stalled consumer back-pressures the issue side without losing data.

Parameters:
- WIDTH, 16, operand/result width; power of two, 4..64.
- PIPE, 2, number of register stages (= latency in cycles); 1..(2*log2(WIDTH)).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand set present.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0: add, 1: subtract.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result this cycle.
- q  out  WIDTH  result.
- cout  out  1  carry-out (add) / not-borrow (sub).
- ovf  out  1  two's-complement signed overflow.
- zero  out  1  q == 0.

Behaviour:
- Arithmetic: bb = sub ? ~b : b; c0 = sub ? ~cin : cin; {cout,q} = a + bb + c0, computed modulo 2^(WIDTH+1).
  - sub=1 yields a - b - cin; cout=1 means no borrow.
- ovf = (a[W-1] == bb[W-1]) && (q[W-1] != a[W-1]).
- zero = (q == 0), registered with q.
- Datapath structure:
  - Per-bit pg stage (p = a ^ bb, g = a & bb).
  - Brent-Kung prefix tree with carry-in folded as bit -1 group generate; L = 2*log2(WIDTH)-1 prefix levels.
  - Final sum XOR.
- Register placement: one pipeline register always on the outputs. The remaining PIPE-1 registers go after prefix level ceil(k*L/PIPE), k = 1..PIPE-1; coincident positions are merged downward. Results are bit-identical for every PIPE.
- Latency: an operand accepted in cycle t appears with out_valid=1 in cycle t+PIPE when no stall occurs. Throughput: 1 per cycle.
- Handshake:
  - Transfer on in_valid && in_ready (input) and on out_valid && out_ready (output).
  - Each stage k has valid bit v_k; ready_k = !v_k || ready_{k+1}; ready_PIPE = out_ready.
  - in_ready = ready_1, which is combinational from out_ready. This is a bubble-collapsing pipeline.
  - A stage holds its data while v_k && !ready_{k+1}.
  - out_valid must not drop, and q/cout/ovf/zero must not change, while out_valid && !out_ready.
- No deadlock: in_ready=1 whenever any stage holds a bubble, regardless of out_ready.
- Simultaneous accept and emit with a full pipeline and out_ready=1: both happen in the same cycle; occupancy is unchanged.
- Reset (asynchronous assert, synchronous-safe deassert by the system):
  - All v_k = 0, out_valid = 0, q = 0, cout = 0, ovf = 0, zero = 0.
  - in_ready = 1 during and after reset.
- Reset mid-operation: all in-flight results are discarded; none are emitted after release.
- Inputs are ignored (no state change) when in_valid=0.
- Width edge cases:
  - WIDTH=4 with maximum PIPE=4 is legal.
  - a = all ones, bb = 0, c0 = 1 gives q = 0, cout = 1, zero = 1 (full carry propagation through the tree).

Test Plan:
1. Reset with in_valid=1 held:
   - During reset: out_valid=0, all outputs 0, in_ready=1.
   - After release: the first accepted a=0x0003, b=0x0004, sub=0, cin=0 gives out_valid exactly PIPE cycles later, with q=0x0007, cout=0, ovf=0, zero=0.
2. Full carry chain, WIDTH=16:
   - a=0xFFFF, b=0x0000, cin=1, sub=0 → q=0x0000, cout=1, zero=1, ovf=0.
   - a=0x7FFF, b=0x0001, cin=0 → q=0x8000, ovf=1, cout=0.
3. Subtract:
   - a=0x0005, b=0x0007, sub=1, cin=0 → q=0xFFFE, cout=0 (borrow).
   - a=0x8000, b=0x0001, sub=1, cin=0 → q=0x7FFF, ovf=1, cout=1.
   - a=0x0005, b=0x0005, sub=1, cin=1 → q=0xFFFF, cout=0.
4. Back-pressure, PIPE=2, streaming 8 back-to-back operands:
   - Hold out_ready=0 for 5 cycles. in_ready must fall after exactly 2 operands are held. Output must stay stable throughout.
   - On release, all 8 results emerge in order, with none lost or duplicated.
5. Bubble collapse:
   - Issue op, 1 idle cycle, op, with out_ready=0 and then released.
   - in_ready must stay 1 until both stages are full. Results come out in consecutive cycles once out_ready=1.
6. Sweep and mid-stream reset:
   - Sweep WIDTH∈{4,16,64} × every legal PIPE with 10k random a/b/cin/sub and random out_ready. Every result must match the reference model.
   - Assert rst_n mid-stream: no stale result may appear after release.
